gtp_rx_pkt: RTL and testbench

- Parametrised next-generation receive-side framer for the GTP/AXI-Stream link, running in the log_clk domain.
- Parses framed packets: SOF, ID, header, payload, CRC32, EOF. Single-word trigger frames are also recognised.
- Payload words are written into a downstream packet RAM at header-supplied addresses.
- Completion, CRC, length and framing status plus statistics counters are reported to the register/control logic.

---
 rtl/gtp_rx_pkt_if.sv | 12 +
 rtl/gtp_rx_pkt.sv | 198 +++++++++++++++++++
 tb/tb_gtp_rx_pkt.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/gtp_rx_pkt_if.sv
// Receive stream bundle (data/valid/last) feeding the GTP frame parser.
// No ready signal: the sink accepts every valid beat.
interface gtp_rx_pkt_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;

  modport master (output tdata, tvalid, tlast);
  modport slave  (input  tdata, tvalid, tlast);
endinterface

// File: rtl/gtp_rx_pkt.sv
// GTP receive framer: parses SOF/ID/HEAD/payload/CRC/EOF, writes payload to packet RAM, reports status.
// Every pulse and write is registered, 1 cycle after its beat; no backpressure, every valid beat is consumed.
module gtp_rx_pkt #(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 8,
  parameter int          LEN_W     = 8,
  parameter int          MAX_LEN   = 255,
  parameter logic [31:0] SOF_WORD  = 32'h0000FFBC,
  parameter logic [31:0] EOF_WORD  = 32'h0000FFBD,
  parameter logic [31:0] TRIG_WORD = 32'h0000FFBA,
  parameter bit          ID_FILTER = 1'b1,
  parameter int          CNT_W     = 16
) (
  input  logic              log_clk,
  input  logic              log_rst_n,
  gtp_rx_pkt_if.slave       s_axi_rx,
  input  logic [DATA_W-1:0] local_id,
  input  logic              id_err_clr,
  input  logic              cnt_clr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rx_id,
  output logic [DATA_W-1:0] rx_head,
  output logic              rx_done,
  output logic              rx_trigger,
  output logic              crc_err,
  output logic              frame_err,
  output logic              id_mismatch,
  output logic [CNT_W-1:0]  good_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_ID, S_HEAD, S_DATA, S_CRC, S_EOF, S_DROP
  } state_t;

  localparam logic [DATA_W-1:0] SOF_W     = DATA_W'(SOF_WORD);
  localparam logic [DATA_W-1:0] EOF_W     = DATA_W'(EOF_WORD);
  localparam logic [DATA_W-1:0] TRIG_W    = DATA_W'(TRIG_WORD);
  // One extra bit so the length check stays meaningful when MAX_LEN fills LEN_W.
  localparam logic [LEN_W:0]    MAX_LEN_C = (LEN_W+1)'(MAX_LEN);
  localparam logic [31:0]       POLY      = 32'h04C11DB7;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [DATA_W-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = DATA_W-1; i >= 0; i--) begin
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? POLY : 32'h0);
    end
    return r;
  endfunction

  state_t              state, state_nxt;
  logic [31:0]         crc, rx_crc;
  logic [LEN_W-1:0]    len_q, idx;
  logic [ADDR_W-1:0]   start_addr;
  logic                done_set, trig_set, crcerr_set, ferr_set, wr_set, mism_set;

  logic                beat, last;
  logic [DATA_W-1:0]   dat;
  logic                len_big, eof_ok, id_ok;

  assign beat    = s_axi_rx.tvalid;
  assign last    = s_axi_rx.tlast;
  assign dat     = s_axi_rx.tdata;
  assign len_big = {1'b0, dat[LEN_W-1:0]} > MAX_LEN_C;
  assign eof_ok  = (dat == EOF_W) && last;
  assign id_ok   = !ID_FILTER || (rx_id == local_id);

  always_ff @(posedge log_clk or negedge log_rst_n) begin
    if (!log_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    done_set   = 1'b0;
    trig_set   = 1'b0;
    crcerr_set = 1'b0;
    ferr_set   = 1'b0;
    wr_set     = 1'b0;
    mism_set   = 1'b0;
    if (beat) begin
      case (state)
        S_IDLE: begin
          if (dat == TRIG_W)     trig_set  = 1'b1;
          else if (dat == SOF_W) state_nxt = S_ID;
          else if (!last)        state_nxt = S_DROP;
        end
        S_ID: begin
          if (last) begin ferr_set = 1'b1; state_nxt = S_IDLE; end
          else state_nxt = S_HEAD;
        end
        S_HEAD: begin
          if (last)                         begin ferr_set = 1'b1; state_nxt = S_IDLE; end
          else if (len_big)                 begin ferr_set = 1'b1; state_nxt = S_DROP; end
          else if (dat[LEN_W-1:0] == '0)    state_nxt = S_CRC;
          else                              state_nxt = S_DATA;
        end
        S_DATA: begin
          if (last) begin
            ferr_set  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            wr_set = id_ok;
            if (idx == len_q - LEN_W'(1)) state_nxt = S_CRC;
          end
        end
        S_CRC: begin
          if (last) begin ferr_set = 1'b1; state_nxt = S_IDLE; end
          else state_nxt = S_EOF;
        end
        S_EOF: begin
          if (eof_ok) begin
            state_nxt = S_IDLE;
            if (crc == rx_crc) begin
              done_set = 1'b1;
              mism_set = (rx_id != local_id);
            end else begin
              crcerr_set = 1'b1;
            end
          end else begin
            ferr_set  = 1'b1;
            state_nxt = last ? S_IDLE : S_DROP;
          end
        end
        S_DROP:  if (last) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge log_clk or negedge log_rst_n) begin
    if (!log_rst_n) begin
      crc        <= '0;
      rx_crc     <= '0;
      len_q      <= '0;
      idx        <= '0;
      start_addr <= '0;
      rx_id      <= '0;
      rx_head    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      rx_done    <= 1'b0;
      rx_trigger <= 1'b0;
      crc_err    <= 1'b0;
      frame_err  <= 1'b0;
      id_mismatch <= 1'b0;
      good_cnt   <= '0;
      err_cnt    <= '0;
    end else begin
      rx_done    <= done_set;
      rx_trigger <= trig_set;
      crc_err    <= crcerr_set;
      frame_err  <= ferr_set;
      wr_en      <= wr_set;
      if (wr_set) begin
        wr_addr <= start_addr + ADDR_W'(idx);
        wr_data <= dat;
      end
      if (beat) begin
        case (state)
          S_IDLE: if (dat == SOF_W) crc <= '1;
          S_ID: begin
            rx_id <= dat;
            crc   <= crc_next(crc, dat);
          end
          S_HEAD: begin
            rx_head    <= dat;
            len_q      <= dat[LEN_W-1:0];
            start_addr <= dat[LEN_W +: ADDR_W];
            idx        <= '0;
            crc        <= crc_next(crc, dat);
          end
          S_DATA: begin
            crc <= crc_next(crc, dat);
            idx <= idx + LEN_W'(1);
          end
          S_CRC:   rx_crc <= 32'(dat);
          default: ;
        endcase
      end
      // Clear wins over a same-cycle set/increment.
      if (id_err_clr)    id_mismatch <= 1'b0;
      else if (mism_set) id_mismatch <= 1'b1;
      if (cnt_clr) begin
        good_cnt <= '0;
        err_cnt  <= '0;
      end else begin
        if (done_set && good_cnt != '1)               good_cnt <= good_cnt + CNT_W'(1);
        if ((crcerr_set || ferr_set) && err_cnt != '1) err_cnt  <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gtp_rx_pkt.sv
// Directed bench for gtp_rx_pkt: framing, CRC, addressing, filtering, error and reset cases.
module tb_gtp_rx_pkt;
  logic        log_clk = 1'b0;
  logic        log_rst_n = 1'b0;
  logic [31:0] local_id;
  logic        id_err_clr, cnt_clr;
  logic        wr_en, rx_done, rx_trigger, crc_err, frame_err, id_mismatch;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data, rx_id, rx_head;
  logic [15:0] good_cnt, err_cnt;

  gtp_rx_pkt_if #(.DATA_W(32)) rx_if ();

  gtp_rx_pkt #(.MAX_LEN(200)) dut (
    .log_clk(log_clk), .log_rst_n(log_rst_n), .s_axi_rx(rx_if),
    .local_id(local_id), .id_err_clr(id_err_clr), .cnt_clr(cnt_clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rx_id(rx_id), .rx_head(rx_head), .rx_done(rx_done), .rx_trigger(rx_trigger),
    .crc_err(crc_err), .frame_err(frame_err), .id_mismatch(id_mismatch),
    .good_cnt(good_cnt), .err_cnt(err_cnt)
  );

  always #5 log_clk = ~log_clk;

  int cyc = 0;
  always @(posedge log_clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Output log, sampled on the falling edge.
  logic [7:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int done_n, crcerr_n, ferr_n, trig_n;
  int done_cyc, crcerr_cyc, ferr_cyc, trig_cyc, first_wr_cyc;
  always @(negedge log_clk) begin
    if (wr_en) begin
      if (wa_q.size() == 0) first_wr_cyc <= cyc;
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
    if (rx_done)    begin done_n   <= done_n + 1;   done_cyc   <= cyc; end
    if (crc_err)    begin crcerr_n <= crcerr_n + 1; crcerr_cyc <= cyc; end
    if (frame_err)  begin ferr_n   <= ferr_n + 1;   ferr_cyc   <= cyc; end
    if (rx_trigger) begin trig_n   <= trig_n + 1;   trig_cyc   <= cyc; end
  end

  task automatic clear_log();
    wa_q.delete(); wd_q.delete();
    done_n = 0; crcerr_n = 0; ferr_n = 0; trig_n = 0;
    done_cyc = -1; crcerr_cyc = -1; ferr_cyc = -1; trig_cyc = -1; first_wr_cyc = -1;
  endtask

  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] t;
    t = c ^ d;
    repeat (32) t = t[31] ? ((t << 1) ^ 32'h04C11DB7) : (t << 1);
    return t;
  endfunction

  int beat_cyc;
  task automatic beat(input logic [31:0] d, input logic last);
    @(negedge log_clk);
    rx_if.tdata = d; rx_if.tvalid = 1'b1; rx_if.tlast = last;
    id_err_clr = 1'b0; cnt_clr = 1'b0;
    beat_cyc = cyc;
  endtask

  // Idle cycles carry a SOF word with tvalid low, which must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge log_clk);
      rx_if.tdata = 32'h0000FFBC; rx_if.tvalid = 1'b0; rx_if.tlast = 1'b1;
      id_err_clr = 1'b0; cnt_clr = 1'b0;
    end
  endtask

  logic [31:0] pl[$];
  int p0_cyc, eof_cyc;
  task automatic frame(input logic [31:0] id, input logic [31:0] hdr, input int bad_idx,
                       input bit gaps, input bit idclr, input bit cclr);
    logic [31:0] c;
    c = crc_model(32'hFFFFFFFF, id);
    c = crc_model(c, hdr);
    foreach (pl[i]) c = crc_model(c, pl[i]);
    beat(32'h0000FFBC, 1'b0); if (gaps) idle(1);
    beat(id, 1'b0);           if (gaps) idle(1);
    beat(hdr, 1'b0);          if (gaps) idle(1);
    for (int i = 0; i < pl.size(); i++) begin
      beat((i == bad_idx) ? (pl[i] ^ 32'h100) : pl[i], 1'b0);
      if (i == 0) p0_cyc = beat_cyc;
      if (gaps) idle(1);
    end
    beat(c, 1'b0); if (gaps) idle(1);
    beat(32'h0000FFBD, 1'b1);
    id_err_clr = idclr; cnt_clr = cclr;
    eof_cyc = beat_cyc;
    idle(3);
  endtask

  task automatic chk_writes(input string tag, input int base, input int n);
    chk({tag, "_nwr"}, wa_q.size(), n);
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      chk({tag, "_addr"}, 32'(wa_q[i]), (base + i) & 'hFF);
      chk({tag, "_data"}, wd_q[i], pl[i]);
    end
  endtask

  initial begin
    local_id = 32'hA5A50001; id_err_clr = 1'b0; cnt_clr = 1'b0;
    rx_if.tdata = '0; rx_if.tvalid = 1'b0; rx_if.tlast = 1'b0;
    clear_log();
    repeat (3) @(negedge log_clk);
    chk("rst_wr_en", wr_en, 0);   chk("rst_done", rx_done, 0);
    chk("rst_trig", rx_trigger, 0); chk("rst_crcerr", crc_err, 0);
    chk("rst_ferr", frame_err, 0); chk("rst_mism", id_mismatch, 0);
    chk("rst_good", good_cnt, 0); chk("rst_errc", err_cnt, 0);
    chk("rst_rx_id", rx_id, 0);   chk("rst_head", rx_head, 0);
    chk("rst_waddr", 32'(wr_addr), 0); chk("rst_wdata", wr_data, 0);
    log_rst_n = 1'b1;
    idle(2);

    // Good frame: start 3, len 5.
    pl = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    clear_log(); frame(local_id, 32'h0305, -1, 0, 0, 0);
    chk_writes("good", 3, 5);
    chk("good_wr_lat", first_wr_cyc, p0_cyc + 1);
    chk("good_done_n", done_n, 1);  chk("good_done_lat", done_cyc, eof_cyc + 1);
    chk("good_crcerr", crcerr_n, 0); chk("good_ferr", ferr_n, 0);
    chk("good_cnt1", good_cnt, 1);  chk("good_errc", err_cnt, 0);
    chk("good_rx_id", rx_id, local_id); chk("good_head", rx_head, 32'h0305);
    chk("good_mism", id_mismatch, 0);

    // Corrupted payload word 3.
    clear_log(); frame(local_id, 32'h0305, 2, 0, 0, 0);
    chk("bad_nwr", wa_q.size(), 5);
    chk("bad_wd2", wd_q[2], 32'h103);
    chk("bad_crcerr", crcerr_n, 1); chk("bad_crc_lat", crcerr_cyc, eof_cyc + 1);
    chk("bad_done", done_n, 0);
    chk("bad_errc", err_cnt, 1);    chk("bad_good", good_cnt, 1);

    // Trigger (tlast low must not cause DROP), then gapped good frame.
    clear_log();
    beat(32'h0000FFBA, 1'b0); idle(2);
    chk("trig_n", trig_n, 1); chk("trig_lat", trig_cyc, beat_cyc + 1);
    frame(local_id, 32'h0305, -1, 1, 0, 0);
    chk_writes("gap", 3, 5);
    chk("gap_done", done_n, 1); chk("gap_crcerr", crcerr_n, 0);
    chk("gap_good", good_cnt, 2);

    // Zero length.
    pl.delete();
    clear_log(); frame(local_id, 32'h0700, -1, 0, 0, 0);
    chk("len0_nwr", wa_q.size(), 0); chk("len0_done", done_n, 1);
    chk("len0_good", good_cnt, 3);

    // Address wrap: start FE, len 4.
    pl = '{32'hA, 32'hB, 32'hC, 32'hD};
    clear_log(); frame(local_id, 32'hFE04, -1, 0, 0, 0);
    chk_writes("wrap", 'hFE, 4);
    chk("wrap_done", done_n, 1);

    // len = MAX_LEN+1: error, then drop through an embedded SOF until tlast.
    clear_log();
    beat(32'h0000FFBC, 1'b0); beat(local_id, 1'b0); beat(32'h00C9, 1'b0);
    beat(32'h0000FFBC, 1'b0); beat(32'h11, 1'b0); beat(32'h0000FFBD, 1'b1);
    idle(3);
    chk("big_ferr", ferr_n, 1); chk("big_nwr", wa_q.size(), 0);
    chk("big_done", done_n, 0); chk("big_errc", err_cnt, 2);

    // Foreign ID: filtered writes, done, sticky mismatch.
    pl = '{32'h21, 32'h22};
    clear_log(); frame(32'h0000DEAD, 32'h1002, -1, 0, 0, 0);
    chk("fid_nwr", wa_q.size(), 0); chk("fid_done", done_n, 1);
    chk("fid_mism", id_mismatch, 1); chk("fid_rx_id", rx_id, 32'h0000DEAD);
    chk("fid_good", good_cnt, 5);
    // Clear arriving with a new mismatch wins.
    clear_log(); frame(32'h0000DEAD, 32'h1002, -1, 0, 1, 0);
    chk("fidclr_done", done_n, 1); chk("fidclr_mism", id_mismatch, 0);

    // Early tlast on second payload beat.
    clear_log();
    beat(32'h0000FFBC, 1'b0); beat(local_id, 1'b0); beat(32'h2004, 1'b0);
    beat(32'h31, 1'b0); beat(32'h32, 1'b1);
    idle(3);
    chk("early_ferr", ferr_n, 1); chk("early_lat", ferr_cyc, beat_cyc + 1);
    chk("early_done", done_n, 0); chk("early_errc", err_cnt, 3);

    // Counter clear coincident with a good-frame increment.
    pl = '{32'h41};
    clear_log(); frame(local_id, 32'h5001, -1, 0, 0, 1);
    chk("cclr_done", done_n, 1); chk("cclr_good", good_cnt, 0);
    chk("cclr_errc", err_cnt, 0);

    // Reset in the middle of DATA.
    beat(32'h0000FFBC, 1'b0); beat(local_id, 1'b0); beat(32'h3004, 1'b0);
    beat(32'h51, 1'b0); beat(32'h52, 1'b0);
    @(negedge log_clk);
    log_rst_n = 1'b0; rx_if.tvalid = 1'b0;
    @(negedge log_clk);
    chk("mrst_wr_en", wr_en, 0); chk("mrst_rx_id", rx_id, 0);
    chk("mrst_head", rx_head, 0); chk("mrst_waddr", 32'(wr_addr), 0);
    log_rst_n = 1'b1;
    idle(2);
    clear_log();
    pl = '{32'h61, 32'h62, 32'h63};
    frame(local_id, 32'h4003, -1, 0, 0, 0);
    chk_writes("post", 'h40, 3);
    chk("post_done", done_n, 1); chk("post_ferr", ferr_n, 0);
    chk("post_good", good_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
